// File: rtl/bp_l15_pkg.sv
// Shared definitions for the BP <-> L1.5 return-path encoder.
//   - FSM state enum for the response encoder
//   - pending-request entry {store, size, addr}
//   - lane-select and byte-reverse helpers
// Return-type codes fall back to the OpenPiton iop.h encodings when iop.h has not
// already been read into this compilation unit.

`ifndef LOAD_RET
`define LOAD_RET 4'b0000
`endif
`ifndef EVICT_REQ
`define EVICT_REQ 4'b0011
`endif
`ifndef ST_ACK
`define ST_ACK 4'b0100
`endif
`ifndef INT_RET
`define INT_RET 4'b0111
`endif

package bp_l15_pkg;

  typedef enum logic [0:0] {
    e_idle,
    e_resp
  } bp_l15_resp_state_e;

  typedef struct packed {
    logic        store;
    logic [2:0]  size;
    logic [39:0] addr;
  } bp_l15_pend_entry_t;

  // L1.5 returns a 16-byte line; addr[3] picks the 8-byte half.
  function automatic logic [63:0] bp_l15_lane_sel(input logic        addr3,
                                                  input logic [63:0] data_0,
                                                  input logic [63:0] data_1);
    return addr3 ? data_1 : data_0;
  endfunction

  function automatic logic [63:0] bp_l15_byte_rev(input logic [63:0] data);
    logic [63:0] rev;
    rev = '0;
    for (int i = 0; i < 8; i++) begin
      rev[8*i +: 8] = data[8*(7-i) +: 8];
    end
    return rev;
  endfunction

endpackage

// File: rtl/bp_l15_pend_fifo.sv
// In-order pending-request queue: circular buffer with wrapping pointers.
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset
//   push_i, data_i   enqueue request (dropped when full)
//   pop_i, data_o    dequeue head (ignored when empty); data_o shows the head
//   full_o, empty_o  occupancy status from the registered count
//   overflow_o       push attempted while full
module bp_l15_pend_fifo
  import bp_l15_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  bp_l15_pend_entry_t data_i,
  input  logic               pop_i,
  output bp_l15_pend_entry_t data_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  bp_l15_pend_entry_t mem_q [Depth];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               push_ok, pop_ok;

  assign full_o     = (count_q == CntW'(Depth));
  assign empty_o    = (count_q == '0);
  assign overflow_o = push_i & full_o;
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;
  assign data_o     = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while the count says valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/bp_l15_resp_encoder.sv
// L1.5 return -> BP memory-response encoder.
// Pairs each LOAD_RET / ST_ACK with the oldest pending request and presents one
// registered response over a valid/ready handshake. INT_RET pulses interrupt_v_o,
// EVICT_REQ is acked and dropped, anything else is acked and flagged.
// Ports:
//   clk_i, reset_i                 clock, asynchronous active-high reset
//   req_*_i, req_ready_o           accepted-request push into the pending queue
//   l15_transducer_*               L1.5 return packet; transducer_l15_req_ack consumes it
//   mem_resp_*                     BP memory response (valid/ready)
//   interrupt_v_o                  one-cycle interrupt pulse
//   unexpected_o                   sticky protocol-error flag, cleared only by reset
// Build option: BP_L15_ENDIAN_SWAP_EN byte-reverses the selected load lane.
module bp_l15_resp_encoder
  import bp_l15_pkg::*;
#(
  parameter int unsigned PEND_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_v_i,
  input  logic        req_store_i,
  input  logic [2:0]  req_size_i,
  input  logic [39:0] req_addr_i,
  output logic        req_ready_o,
  input  logic        l15_transducer_val,
  input  logic [3:0]  l15_transducer_returntype,
  input  logic [1:0]  l15_transducer_error,
  input  logic [63:0] l15_transducer_data_0,
  input  logic [63:0] l15_transducer_data_1,
  output logic        transducer_l15_req_ack,
  output logic        mem_resp_v_o,
  input  logic        mem_resp_ready_i,
  output logic        mem_resp_store_o,
  output logic [2:0]  mem_resp_size_o,
  output logic [39:0] mem_resp_addr_o,
  output logic [63:0] mem_resp_data_o,
  output logic        mem_resp_err_o,
  output logic        interrupt_v_o,
  output logic        unexpected_o
);

  bp_l15_resp_state_e state_q, state_d;
  bp_l15_pend_entry_t resp_q, resp_d;
  logic [63:0]        data_q, data_d;
  logic               store_q, store_d;
  logic               err_q, err_d;
  logic               int_q, int_d;
  logic               unexp_q, unexp_d;

  bp_l15_pend_entry_t push_entry, head;
  logic               pop, full, empty, overflow;
  logic [63:0]        lane, lane_fmt;
  logic               is_mem_ret, is_st_ack;

  assign push_entry = '{store: req_store_i, size: req_size_i, addr: req_addr_i};

  bp_l15_pend_fifo #(
    .Depth (PEND_DEPTH)
  ) u_pend_fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .push_i     (req_v_i),
    .data_i     (push_entry),
    .pop_i      (pop),
    .data_o     (head),
    .full_o     (full),
    .empty_o    (empty),
    .overflow_o (overflow)
  );

  assign req_ready_o = ~full;

  assign is_st_ack  = (l15_transducer_returntype == `ST_ACK);
  assign is_mem_ret = is_st_ack || (l15_transducer_returntype == `LOAD_RET);

  always_comb begin
    lane = bp_l15_lane_sel(head.addr[3], l15_transducer_data_0, l15_transducer_data_1);
`ifdef BP_L15_ENDIAN_SWAP_EN
    lane_fmt = bp_l15_byte_rev(lane);
`else
    lane_fmt = lane;
`endif
  end

  always_comb begin
    state_d                = state_q;
    resp_d                 = resp_q;
    data_d                 = data_q;
    store_d                = store_q;
    err_d                  = err_q;
    int_d                  = 1'b0;
    unexp_d                = unexp_q | overflow;
    pop                    = 1'b0;
    transducer_l15_req_ack = 1'b0;
    case (state_q)
      e_idle: begin
        if (l15_transducer_val) begin
          transducer_l15_req_ack = 1'b1;
          if (is_mem_ret) begin
            if (!empty) begin
              pop     = 1'b1;
              resp_d  = head;
              store_d = is_st_ack;
              err_d   = |l15_transducer_error;
              data_d  = is_st_ack ? 64'h0 : lane_fmt;
              state_d = e_resp;
            end else begin
              unexp_d = 1'b1;
            end
          end else if (l15_transducer_returntype == `INT_RET) begin
            int_d = 1'b1;
          end else if (l15_transducer_returntype != `EVICT_REQ) begin
            unexp_d = 1'b1;
          end
        end
      end
      e_resp: begin
        if (mem_resp_ready_i) state_d = e_idle;
      end
      default: state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      resp_q  <= '0;
      data_q  <= '0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      int_q   <= 1'b0;
      unexp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
      store_q <= store_d;
      err_q   <= err_d;
      int_q   <= int_d;
      unexp_q <= unexp_d;
    end
  end

  assign mem_resp_v_o     = (state_q == e_resp);
  assign mem_resp_store_o = store_q;
  assign mem_resp_size_o  = resp_q.size;
  assign mem_resp_addr_o  = resp_q.addr;
  assign mem_resp_data_o  = data_q;
  assign mem_resp_err_o   = err_q;
  assign interrupt_v_o    = int_q;
  assign unexpected_o     = unexp_q;

endmodule

// File: doc/bp_l15_resp_encoder.md
# bp_l15_resp_encoder

Return-path stage paired with the BP→L1.5 request decoder. It accepts L1.5 return packets (load data, store acks, interrupts, invalidations) and pairs each memory return with the oldest outstanding request from an in-order pending queue. It delivers one BP-side memory response per request over a valid/ready handshake. It sits between the L1.5 return interface and the BP memory-response consumer.

## Interface
- PEND_DEPTH, 2: pending-request queue depth; power of two, ≥2.
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- req_v_i  in  1  request accepted by L1.5 this cycle (decoder val & l15_transducer_ack); pushes the pending queue.
- req_store_i  in  1  accepted request is a store.
- req_size_i  in  3  PCX size code of the accepted request.
- req_addr_i  in  40  address of the accepted request.
- req_ready_o  out  1  pending queue not full; the decoder's val is gated by this signal.
- l15_transducer_val  in  1  L1.5 return valid.
- l15_transducer_returntype  in  4  iop.h return type.
- l15_transducer_error  in  2  nonzero means bus error.
- l15_transducer_data_0  in  64  return data, lane 0.
- l15_transducer_data_1  in  64  return data, lane 1.
- transducer_l15_req_ack  out  1  return consumed.
- mem_resp_v_o  out  1  response valid.
- mem_resp_ready_i  in  1  consumer ready.
- mem_resp_store_o  out  1  response is a store ack.
- mem_resp_size_o  out  3  copied from the pending entry.
- mem_resp_addr_o  out  40  copied from the pending entry.
- mem_resp_data_o  out  64  load data; 0 for stores.
- mem_resp_err_o  out  1  error field was nonzero.
- interrupt_v_o  out  1  one-cycle pulse on INT_RET.
- unexpected_o  out  1  sticky protocol-error flag.

## Operation
- Pending queue: in-order. Push on req_v_i. Pushing while full is illegal; it is dropped and sets unexpected_o.
- FSM states: e_idle, e_resp.
- e_idle, l15_transducer_val=1:
  - Assert transducer_l15_req_ack combinationally in the same cycle.
  - Decode the return type.
- LOAD_RET or ST_ACK with the queue non-empty:
  - Pop the queue and register the response.
  - Data lane = req_addr[3] ? data_1 : data_0.
  - Data is forced to 0 for ST_ACK.
  - Go to e_resp.
- LOAD_RET or ST_ACK with the queue empty: drop the return, set unexpected_o, stay in e_idle.
- INT_RET: pulse interrupt_v_o the next cycle, no pop, stay in e_idle.
- EVICT_REQ (invalidation): ack and discard; BP keeps no L1.5-coherent lines on this path.
- Any other return type: ack, discard, set unexpected_o.
- e_resp:
  - mem_resp_v_o=1, transducer_l15_req_ack=0.
  - On mem_resp_v_o & mem_resp_ready_i, return to e_idle.
- A push and a pop in the same cycle are both performed; occupancy is unchanged.

## Timing
- L1.5 valid → mem_resp_v_o: 1 cycle (registered).
- Back-to-back returns: at most one return per 2 cycles when the consumer is always ready. No combinational path from mem_resp_ready_i to transducer_l15_req_ack.
- req_ready_o is derived from registered occupancy only. It reads 0 whenever count==PEND_DEPTH, even if a pop occurs that same cycle.
- Response outputs are held stable while mem_resp_v_o=1 and ready=0.
- Reset values:
  - FSM = e_idle; queue empty.
  - All outputs 0, except req_ready_o=1.
  - unexpected_o is cleared only by reset.
- Reset mid-operation:
  - Any buffered response and all pending entries are discarded.
  - The L1.5 must be reset in the same window.

## Configuration
- Macro: BP_L15_ENDIAN_SWAP_EN.
- Defined: the selected 64-bit lane is byte-reversed before registering, converting OpenPiton big-endian data to BP little-endian.
- Undefined: the lane is passed through unchanged.
- Store acks are 0 either way.

## Structure
- Shared package bp_l15_pkg holds:
  - FSM state enum.
  - Pending-entry struct {store, size[2:0], addr[39:0]}.
  - Lane-select and byte-reverse helper functions.
- Return-type codes come from iop.h macros (`LOAD_RET, `ST_ACK, `INT_RET, `EVICT_REQ).
- One sub-module, bp_l15_pend_fifo: parameterised-depth circular FIFO with pointer wrap and a count of log2(PEND_DEPTH)+1 bits; exposes full/empty.

## Test plan
- Push load addr 0x80_0000_0008 size 8B; LOAD_RET with data_0=0x1111…, data_1=0x0123_4567_89AB_CDEF → next cycle mem_resp_v_o=1, addr matches. Data = 0x0123456789ABCDEF with the macro undefined, 0xEFCDAB8967452301 with it defined.
- Push store then load; ST_ACK then LOAD_RET, consumer ready held low 3 cycles → store response held stable with data 0; load response follows in order; second ack waits until e_idle.
- Fill queue (2 pushes) → req_ready_o=0; one return consumed → req_ready_o=1 the cycle after the pop.
- LOAD_RET with queue empty → ack=1, no response, unexpected_o=1 until reset.
- INT_RET, then EVICT_REQ → interrupt_v_o pulses exactly 1 cycle, both acked, queue count unchanged, mem_resp_v_o stays 0.
- Assert reset_i asynchronously while in e_resp with 1 pending entry → mem_resp_v_o falls immediately, req_ready_o=1, the next LOAD_RET flags unexpected_o.
